lbp_image_host: RTL and testbench

//  Memory-side responder for the LBP engine's gray/lbp interface. Accepts a raster-order

---
 rtl/lbp_image_host.sv | 111 +++++++++++
 tb/tb_lbp_image_host.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lbp_image_host.sv
// Frame buffer host for the LBP engine: loads a gray image, serves zero-latency reads,
// captures LBP results and streams the result frame out in address order.
module lbp_image_host #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_data,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_gray_ready;
  logic [DW-1:0] r_gray_mem [DEPTH];
  logic [DW-1:0] r_lbp_mem  [DEPTH];

  logic w_load_hs;
  logic w_out_hs;
  logic w_wr_last;
  logic w_rd_last;
  logic w_serve;

  assign w_serve   = (r_state == S_SERVE);
  assign w_load_hs = (r_state == S_LOAD) && load_valid;
  assign w_out_hs  = (r_state == S_DRAIN) && out_ready;
  assign w_wr_last = &r_wr_ptr;
  assign w_rd_last = &r_rd_ptr;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && w_wr_last) w_next = S_SERVE;
      end
      S_SERVE: begin
        if (finish) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_rd_last;
        if (out_ready && w_rd_last) w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: w_next = S_LOAD;
    endcase
  end

  assign gray_ready = r_gray_ready;
  assign gray_data  = (w_serve && gray_req) ? r_gray_mem[gray_addr] : '0;
  assign out_data   = (r_state == S_DRAIN) ? r_lbp_mem[r_rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_gray_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_hs && !w_wr_last) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_out_hs && !w_rd_last)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Dropped for good on the first request so the core cannot restart after finish.
      if (w_load_hs && w_wr_last)
        r_gray_ready <= 1'b1;
      else if (w_serve && (gray_req || finish))
        r_gray_ready <= 1'b0;
    end
  end

  // NOTE: the frame memories carry no reset; every load rewrites both before they are read.
  always_ff @(posedge clk) begin
    if (w_load_hs) begin
      r_gray_mem[r_wr_ptr] <= load_data;
      r_lbp_mem[r_wr_ptr]  <= '0;
    end else if (w_serve && lbp_valid) begin
      r_lbp_mem[lbp_addr] <= lbp_data;
    end
  end

endmodule

// File: tb/tb_lbp_image_host.sv
// Directed-plus-random bench for lbp_image_host at AW=4: reference frame arrays predict
// every gray read and every drained result word.
module tb_lbp_image_host;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] gray_model [DEPTH];
  logic [DW-1:0] lbp_model  [DEPTH];

  always #5 clk = ~clk;

  lbp_image_host #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = '0;
    gray_req   = 1'b0; gray_addr = '0;
    lbp_valid  = 1'b0; lbp_addr  = '0; lbp_data = '0;
    finish     = 1'b0; out_ready = 1'b0;
  endtask

  // Loads a full frame with load_valid held high; a stray lbp write to address 0 must be ignored.
  task automatic load_frame(input bit ramp);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = ramp ? DW'(i) : DW'($urandom);
      gray_model[i] = load_data;
      lbp_model[i]  = '0;
      lbp_valid = (i > 0); lbp_addr = '0; lbp_data = 8'h5A;
      gray_req  = 1'b1;   gray_addr = '0;
      #1;
      check("load_ready_in_load", load_ready, 1);
      check("gray_data_in_load", gray_data, 0);
    end
    @(negedge clk);
    load_data = 8'hEE; lbp_valid = 1'b0; gray_req = 1'b0;
    #1;
    check("load_ready_after_frame", load_ready, 0);
    check("gray_ready_first_serve", gray_ready, 1);
    load_valid = 1'b0;
  endtask

  // First read in the list uses first_addr; gray_ready must drop the cycle after it.
  task automatic gray_reads(input int n, input int first_addr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      gray_req  = 1'b1;
      gray_addr = (k == 0) ? AW'(first_addr) : AW'($urandom);
      #1;
      check("gray_data_read", gray_data, gray_model[gray_addr]);
      check("gray_ready_during_reads", gray_ready, (k == 0) ? 1 : 0);
    end
    @(negedge clk);
    gray_req = 1'b0; gray_addr = AW'($urandom);
    #1;
    check("gray_data_no_req", gray_data, 0);
    check("gray_ready_stays_low", gray_ready, 0);
  endtask

  task automatic lbp_write(input int addr, input int data, input bit fin, input bit valid);
    @(negedge clk);
    lbp_valid = valid; lbp_addr = AW'(addr); lbp_data = DW'(data); finish = fin;
    if (valid) lbp_model[addr] = DW'(data);
    #1;
    check("gray_ready_low_while_writing", gray_ready, 0);
    check("out_valid_low_in_serve", out_valid, 0);
  endtask

  // Drains until stop_at words are accepted; DRAIN-state lbp/gray inputs must be ignored.
  task automatic drain(input bit random_ready, input int stop_at);
    int idx = 0;
    int cycles = 0;
    while (idx < stop_at && cycles < 400) begin
      @(negedge clk);
      lbp_valid = 1'b0; finish = 1'b0;
      if (random_ready) begin
        lbp_valid = 1'b1; lbp_addr = AW'(DEPTH - 1); lbp_data = 8'h77;
        gray_req  = 1'b1; gray_addr = AW'($urandom);
      end
      out_ready = random_ready ? 1'($urandom % 2) : 1'b1;
      #1;
      check("out_valid_drain", out_valid, 1);
      check("out_data_drain", out_data, lbp_model[idx]);
      check("out_last_drain", out_last, (idx == DEPTH - 1) ? 1 : 0);
      check("gray_data_in_drain", gray_data, 0);
      if (out_ready) idx++;
      cycles++;
    end
    check("drain_handshakes", idx, stop_at);
    lbp_valid = 1'b0; gray_req = 1'b0;
  endtask

  task automatic expect_done();
    @(negedge clk);
    out_ready = 1'b0; lbp_valid = 1'b1; finish = 1'b1; gray_req = 1'b1;
    #1;
    check("out_valid_after_last", out_valid, 0);
    check("done_after_last", done, 1);
    check("load_ready_in_done", load_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    check("done_held", done, 1);
    check("gray_ready_in_done", gray_ready, 0);
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_load_ready", load_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_done", done, 0);
    check("reset_gray_ready", gray_ready, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    do_reset();

    // Frame 1: ramp image, directed writes with a finish-coincident write, full-rate drain.
    load_frame(1'b1);
    gray_reads(3, 5);
    lbp_write(5, 8'h11, 1'b0, 1'b1);
    lbp_write(5, 8'hA5, 1'b0, 1'b1);
    lbp_write(6, 8'h3C, 1'b0, 1'b1);
    lbp_write(9, 8'hFF, 1'b1, 1'b1);
    drain(1'b0, DEPTH);
    expect_done();

    // Frame 2: random image, random writes, finish without a write, random backpressure.
    do_reset();
    load_frame(1'b0);
    gray_reads(6, $urandom_range(0, DEPTH - 1));
    for (int w = 0; w < 10; w++)
      lbp_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 255), 1'b0, 1'($urandom % 2));
    lbp_write(0, 0, 1'b1, 1'b0);
    drain(1'b1, DEPTH);
    expect_done();

    // Frame 3: reset mid-drain at rd_ptr 7, then a clean frame must drain all zeros.
    do_reset();
    load_frame(1'b0);
    gray_reads(1, 3);
    for (int w = 0; w < 6; w++)
      lbp_write($urandom_range(1, DEPTH - 2), $urandom_range(1, 255), 1'b0, 1'b1);
    lbp_write(8, 8'h42, 1'b1, 1'b1);
    drain(1'b1, 7);
    @(negedge clk);
    out_ready = 1'b0;
    check("pre_abort_out_data", out_data, lbp_model[7]);
    reset = 1'b1;
    #1;
    check("abort_load_ready", load_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    load_frame(1'b0);
    gray_reads(2, 0);
    lbp_write(0, 0, 1'b1, 1'b0);
    drain(1'b0, DEPTH);
    expect_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
